// File: rtl/seg7_sequence_checker.sv
// seg7_sequence_checker
//   Decodes a seven-segment pattern stream into hex digits and tracks whether
//   consecutive digits form an up-counting or down-counting sequence. Breaks
//   in a locked sequence and illegal patterns are flagged and counted in a
//   saturating error counter.
//
// Parameters
//   ERR_W        width of the saturating error counter (>= 2)
//
// Ports
//   clk_2        clock, rising edge
//   reset        synchronous, active-high reset
//   sample_en    seg_in is consumed at this edge when high
//   seg_in[7:0]  segment pattern, bit0=a .. bit6=g, bit7=decimal point
//   err_clr      clears err_count (wins over a simultaneous increment)
//   digit[3:0]   last successfully decoded hex value
//   digit_valid  pulse: digit updated by the last edge
//   state[1:0]   0=SEARCH 1=TRACK 2=LOCK_UP 3=LOCK_DOWN
//   err_invalid  pulse: last sample was not a legal pattern
//   err_seq      pulse: a locked sequence was broken
//   dir_change   pulse: direct LOCK_UP <-> LOCK_DOWN transition
//   err_count    saturating count of err_invalid + err_seq events
//
// Build option
//   SEG7_DP_CHECK_EN  when defined, a lit decimal point makes the sample invalid;
//                     otherwise bit 7 is ignored.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SEARCH    | no usable previous digit (after reset or an invalid sample)
// TRACK     | one valid digit seen, direction not yet established
// LOCK_UP   | digits are advancing by +1 (mod 16)
// LOCK_DOWN | digits are advancing by -1 (mod 16)

module seg7_sequence_checker #(
  parameter int ERR_W = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [7:0]       seg_in,
  input  logic             err_clr,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic [1:0]       state,
  output logic             err_invalid,
  output logic             err_seq,
  output logic             dir_change,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    TRACK     = 2'd1,
    LOCK_UP   = 2'd2,
    LOCK_DOWN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       digit_d;
  logic             valid_d, inv_d, seq_d, dir_d;
  logic [ERR_W-1:0] count_d;

  logic [3:0]       dec_digit;
  logic             dec_ok;
  logic             sample_ok;
  logic [3:0]       digit_up, digit_down;
  logic             step_up, step_down, step_hold;

  // Segment decode on bits 6:0.
  always_comb begin
    dec_ok    = 1'b1;
    dec_digit = 4'h0;
    case (seg_in[6:0])
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      default: dec_ok  = 1'b0;
    endcase
  end

`ifdef SEG7_DP_CHECK_EN
  assign sample_ok = dec_ok & ~seg_in[7];
`else
  assign sample_ok = dec_ok;
`endif

  // 4-bit arithmetic wraps naturally, so F->0 counts as up and 0->F as down.
  assign digit_up   = digit + 4'd1;
  assign digit_down = digit - 4'd1;
  assign step_up    = (dec_digit == digit_up);
  assign step_down  = (dec_digit == digit_down);
  assign step_hold  = (dec_digit == digit);

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q     <= SEARCH;
      digit       <= 4'h0;
      digit_valid <= 1'b0;
      err_invalid <= 1'b0;
      err_seq     <= 1'b0;
      dir_change  <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      digit       <= digit_d;
      digit_valid <= valid_d;
      err_invalid <= inv_d;
      err_seq     <= seq_d;
      dir_change  <= dir_d;
      err_count   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit;
    valid_d = 1'b0;
    inv_d   = 1'b0;
    seq_d   = 1'b0;
    dir_d   = 1'b0;
    if (sample_en) begin
      if (!sample_ok) begin
        inv_d   = 1'b1;
        state_d = SEARCH;
      end else begin
        digit_d = dec_digit;
        valid_d = 1'b1;
        case (state_q)
          SEARCH: state_d = TRACK;
          TRACK: begin
            if (step_up)        state_d = LOCK_UP;
            else if (step_down) state_d = LOCK_DOWN;
          end
          LOCK_UP: begin
            if (step_down) begin
              state_d = LOCK_DOWN;
              dir_d   = 1'b1;
            end else if (!step_up && !step_hold) begin
              state_d = TRACK;
              seq_d   = 1'b1;
            end
          end
          LOCK_DOWN: begin
            if (step_up) begin
              state_d = LOCK_UP;
              dir_d   = 1'b1;
            end else if (!step_down && !step_hold) begin
              state_d = TRACK;
              seq_d   = 1'b1;
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  // Clear wins over a same-edge increment; the counter sticks at all-ones.
  always_comb begin
    count_d = err_count;
    if (err_clr)
      count_d = '0;
    else if ((inv_d || seq_d) && !(&err_count))
      count_d = err_count + {{(ERR_W-1){1'b0}}, 1'b1};
  end

  assign state = state_q;

endmodule

// File: tb/tb_seg7_sequence_checker.sv
module tb_seg7_sequence_checker;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic       err_clr = 1'b0;

  logic [3:0] digit, digit_b;
  logic       digit_valid, digit_valid_b;
  logic [1:0] state, state_b;
  logic       err_invalid, err_invalid_b;
  logic       err_seq, err_seq_b;
  logic       dir_change, dir_change_b;
  logic [7:0] err_count;
  logic [1:0] err_count_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_2 = ~clk_2;

  seg7_sequence_checker #(.ERR_W(8)) dut (
    .clk_2(clk_2), .reset(reset), .sample_en(sample_en), .seg_in(seg_in),
    .err_clr(err_clr), .digit(digit), .digit_valid(digit_valid), .state(state),
    .err_invalid(err_invalid), .err_seq(err_seq), .dir_change(dir_change),
    .err_count(err_count));

  seg7_sequence_checker #(.ERR_W(2)) dut_small (
    .clk_2(clk_2), .reset(reset), .sample_en(sample_en), .seg_in(seg_in),
    .err_clr(err_clr), .digit(digit_b), .digit_valid(digit_valid_b), .state(state_b),
    .err_invalid(err_invalid_b), .err_seq(err_seq_b), .dir_change(dir_change_b),
    .err_count(err_count_b));

  // Reference model: digit value and sequence class as plain integers.
  logic [6:0] pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int m_state = 0, m_digit = 0, m_cnt8 = 0, m_cnt2 = 0;
  int m_valid = 0, m_inv = 0, m_seq = 0, m_dir = 0;

  function automatic int lookup(input logic [7:0] s);
    int r;
    r = -1;
    for (int i = 0; i < 16; i++)
      if (pats[i] == s[6:0]) r = i;
`ifdef SEG7_DP_CHECK_EN
    if (s[7]) r = -1;
`endif
    return r;
  endfunction

  task automatic model_step(input logic r, input logic en, input logic [7:0] s, input logic c);
    int d, diff;
    m_valid = 0; m_inv = 0; m_seq = 0; m_dir = 0;
    if (r) begin
      m_state = 0; m_digit = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    if (en) begin
      d = lookup(s);
      if (d < 0) begin
        m_inv = 1; m_state = 0;
      end else begin
        m_valid = 1;
        diff = (d - m_digit + 16) % 16;
        if (m_state == 0) m_state = 1;
        else if (diff == 1) begin
          if (m_state == 3) m_dir = 1;
          m_state = 2;
        end else if (diff == 15) begin
          if (m_state == 2) m_dir = 1;
          m_state = 3;
        end else if (diff != 0) begin
          if (m_state >= 2) m_seq = 1;
          m_state = 1;
        end
        m_digit = d;
      end
    end
    if (c) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (m_inv + m_seq > 0) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic en, input logic [7:0] s, input logic c);
    reset = r; sample_en = en; seg_in = s; err_clr = c;
    @(posedge clk_2);
    model_step(r, en, s, c);
    #1;
  endtask

  task automatic check_model();
    check("digit", int'(digit), m_digit);
    check("digit_valid", int'(digit_valid), m_valid);
    check("state", int'(state), m_state);
    check("err_invalid", int'(err_invalid), m_inv);
    check("err_seq", int'(err_seq), m_seq);
    check("dir_change", int'(dir_change), m_dir);
    check("err_count", int'(err_count), m_cnt8);
    check("err_count_w2", int'(err_count_b), m_cnt2);
    check("state_w2", int'(state_b), m_state);
  endtask

  typedef struct {
    logic       r, en, c;
    logic [7:0] s;
    int         dg, vl, st, inv, sq, dr, cnt;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(input logic r, input logic en, input logic [7:0] s, input logic c,
                             input int dg, input int vl, input int st, input int inv,
                             input int sq, input int dr, input int cnt);
    vec_t x;
    x.r = r; x.en = en; x.s = s; x.c = c;
    x.dg = dg; x.vl = vl; x.st = st; x.inv = inv; x.sq = sq; x.dr = dr; x.cnt = cnt;
    return x;
  endfunction

  initial begin
    int r, d;
    logic [7:0] s;

    //           rst en  seg    clr  dig vl st inv sq dr cnt
    tbl.push_back(v(1, 1, 8'h06, 1,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 8'h3F, 0,   0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 8'h06, 0,   1, 1, 2, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 8'h5B, 0,   2, 1, 2, 0, 0, 0, 0));
    for (int i = 3; i <= 14; i++)
      tbl.push_back(v(0, 1, {1'b0, pats[i]}, 0, i, 1, 2, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 8'h71, 0,  15, 1, 2, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 8'h3F, 0,   0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 8'h06, 0,   1, 1, 2, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 8'h3F, 0,   0, 1, 3, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 8'h71, 0,  15, 1, 3, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 8'h3F, 0,   0, 1, 2, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 8'h06, 0,   1, 1, 2, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 8'h5B, 0,   2, 1, 2, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 8'h6D, 0,   5, 1, 1, 0, 1, 0, 1));
    tbl.push_back(v(0, 1, 8'h00, 0,   5, 0, 0, 1, 0, 0, 2));
    tbl.push_back(v(0, 0, 8'h3F, 0,   5, 0, 0, 0, 0, 0, 2));
    tbl.push_back(v(0, 0, 8'h3F, 1,   5, 0, 0, 0, 0, 0, 0));

    #2;
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].en, tbl[i].s, tbl[i].c);
      check($sformatf("tbl%0d.digit", i), int'(digit), tbl[i].dg);
      check($sformatf("tbl%0d.valid", i), int'(digit_valid), tbl[i].vl);
      check($sformatf("tbl%0d.state", i), int'(state), tbl[i].st);
      check($sformatf("tbl%0d.inv", i), int'(err_invalid), tbl[i].inv);
      check($sformatf("tbl%0d.seq", i), int'(err_seq), tbl[i].sq);
      check($sformatf("tbl%0d.dir", i), int'(dir_change), tbl[i].dr);
      check($sformatf("tbl%0d.cnt", i), int'(err_count), tbl[i].cnt);
    end

    // Direction change at 4, hold, saturation of the narrow counter, clear vs error.
    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i <= 4; i++) cyc(0, 1, {1'b0, pats[i]}, 0);
    check("lock_at4.state", int'(state), 2);
    cyc(0, 1, 8'h4F, 0);
    check("dirchg.pulse", int'(dir_change), 1);
    check("dirchg.state", int'(state), 3);
    cyc(0, 1, 8'h4F, 0);
    check("hold.dir", int'(dir_change), 0);
    check("hold.state", int'(state), 3);
    check("hold.valid", int'(digit_valid), 1);
    check("hold.seq", int'(err_seq), 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0);
    check("sat.w2", int'(err_count_b), 3);
    check("sat.w8", int'(err_count), 4);
    cyc(0, 1, 8'h00, 1);
    check("clr_err.inv", int'(err_invalid), 1);
    check("clr_err.w2", int'(err_count_b), 0);
    check("clr_err.w8", int'(err_count), 0);

    // Reset while locked down discards the previous digit.
    cyc(0, 1, 8'h5B, 0);
    cyc(0, 1, 8'h06, 0);
    cyc(0, 1, 8'h3F, 0);
    check("pre_rst.state", int'(state), 3);
    cyc(1, 1, 8'h06, 0);
    check("rst.state", int'(state), 0);
    check("rst.digit", int'(digit), 0);
    cyc(0, 1, 8'h06, 0);
    check("post_rst1.state", int'(state), 1);
    check("post_rst1.digit", int'(digit), 1);
    cyc(0, 1, 8'h5B, 0);
    check("post_rst2.state", int'(state), 2);
    check("post_rst2.digit", int'(digit), 2);
    check("post_rst2.cnt", int'(err_count), 0);

    // Decimal point handling.
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'hBF, 0);
`ifdef SEG7_DP_CHECK_EN
    check("dp.inv", int'(err_invalid), 1);
    check("dp.valid", int'(digit_valid), 0);
    check("dp.cnt", int'(err_count), 1);
`else
    check("dp.inv", int'(err_invalid), 0);
    check("dp.valid", int'(digit_valid), 1);
    check("dp.digit", int'(digit), 0);
    check("dp.state", int'(state), 1);
`endif
    check_model();

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      d = (m_digit + 1) % 16;
      else if (r < 60) d = (m_digit + 15) % 16;
      else if (r < 70) d = m_digit;
      else             d = $urandom_range(0, 15);
      s = {1'b0, pats[d]};
      if ($urandom_range(0, 99) < 8) s[7] = 1'b1;
      if ($urandom_range(0, 99) < 10) s = 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 88) ? 1'b1 : 1'b0,
          s,
          ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
